// File: rtl/block_feed_sched_pkg.sv
// block_pkg: lane count, watchdog limit and FSM state encoding shared by block_feed_sched.
package block_pkg;
  localparam int LANES = 8;
  localparam int WD_LIMIT = 64;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, STREAM, WAIT, CAPT, HOLD} state_t;
endpackage

// File: rtl/bfs_skew_buf.sv
// bfs_skew_buf: beat buffer plus registered lane-skew mux driving the array edges.
module bfs_skew_buf
  import block_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int K_BEATS = 8,
  parameter int CW = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [CW-1:0]                wr_idx,
  input  logic [LANES*4*BIT_WIDTH-1:0] wr_north,
  input  logic [LANES*4*BIT_WIDTH-1:0] wr_west,
  input  logic                         sk_en,
  input  logic [CW-1:0]                sk_s,
  output logic [LANES*4*BIT_WIDTH-1:0] arr_north,
  output logic [LANES*4*BIT_WIDTH-1:0] arr_west
);
  localparam int W = 4*BIT_WIDTH;
  logic [LANES*W-1:0] bn_q [K_BEATS];
  logic [LANES*W-1:0] bw_q [K_BEATS];
  logic [LANES*W-1:0] north_d, west_d, north_q, west_q;
  always_ff @(posedge clk)
    for (int k = 0; k < K_BEATS; k++)
      if (wr_en && wr_idx == CW'(k)) begin
        bn_q[k] <= wr_north;
        bw_q[k] <= wr_west;
      end
  // lane j shows beat k exactly when s == j + k; all other slots stay zero
  always_comb begin
    north_d = '0;
    west_d = '0;
    for (int j = 0; j < LANES; j++)
      for (int k = 0; k < K_BEATS; k++)
        if (sk_en && sk_s == CW'(j+k)) begin
          north_d[j*W +: W] = bn_q[k][j*W +: W];
          west_d[j*W +: W] = bw_q[k][j*W +: W];
        end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      north_q <= '0;
      west_q <= '0;
    end else begin
      north_q <= north_d;
      west_q <= west_d;
    end
  assign arr_north = north_q;
  assign arr_west = west_q;
endmodule

// File: rtl/block_feed_sched.sv
// block_feed_sched: loads K_BEATS beats, streams them skewed into the array and returns its result row.
// Optional BFS_WATCHDOG_EN aborts a WAIT that sees no arr_done within WD_LIMIT cycles.
module block_feed_sched
  import block_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int K_BEATS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*4*BIT_WIDTH-1:0] in_north,
  input  logic [LANES*4*BIT_WIDTH-1:0] in_west,
  output logic [LANES*4*BIT_WIDTH-1:0] arr_north,
  output logic [LANES*4*BIT_WIDTH-1:0] arr_west,
  output logic                         arr_clr_n,
  input  logic                         arr_done,
  input  logic [16*BIT_WIDTH-1:0]      arr_row,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [16*BIT_WIDTH-1:0]      res_data,
  output logic                         res_err
);
  localparam int CW = $clog2(K_BEATS+LANES);
  localparam logic [CW-1:0] LOAD_LAST = CW'(K_BEATS-1);
  localparam logic [CW-1:0] STREAM_LAST = CW'(K_BEATS+LANES-2);
  if (FRAC_WIDTH >= BIT_WIDTH) begin : g_frac_check
    $error("FRAC_WIDTH must be smaller than BIT_WIDTH");
  end
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16*BIT_WIDTH-1:0] res_data_q, res_data_d;
  logic clr_n_q;
`ifdef BFS_WATCHDOG_EN
  localparam int DW = $clog2(WD_LIMIT);
  logic [DW-1:0] wd_q, wd_d;
  logic err_q, err_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    res_data_d = res_data_q;
`ifdef BFS_WATCHDOG_EN
    wd_d = '0;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = CLEAR;
        cnt_d = '0;
`ifdef BFS_WATCHDOG_EN
        err_d = 1'b0;
`endif
      end
      CLEAR: state_d = LOAD;
      LOAD: if (in_valid) begin
        cnt_d = cnt_q == LOAD_LAST ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == LOAD_LAST ? STREAM : LOAD;
      end
      STREAM: begin
        cnt_d = cnt_q == STREAM_LAST ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == STREAM_LAST ? WAIT : STREAM;
      end
      WAIT: begin
        if (arr_done) state_d = CAPT;
`ifdef BFS_WATCHDOG_EN
        else if (wd_q == DW'(WD_LIMIT-1)) begin
          state_d = HOLD;
          res_data_d = '0;
          err_d = 1'b1;
        end else wd_d = wd_q + 1'b1;
`endif
      end
      CAPT: begin
        res_data_d = arr_row;
        state_d = HOLD;
      end
      HOLD: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      res_data_q <= '0;
      clr_n_q <= 1'b0;
`ifdef BFS_WATCHDOG_EN
      wd_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      res_data_q <= res_data_d;
      clr_n_q <= state_d != CLEAR;
`ifdef BFS_WATCHDOG_EN
      wd_q <= wd_d;
      err_q <= err_d;
`endif
    end
  // skew outputs are registered, so they are driven from the next-state view
  bfs_skew_buf #(.BIT_WIDTH(BIT_WIDTH), .K_BEATS(K_BEATS), .CW(CW)) u_skew (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(state_q == LOAD && in_valid),
    .wr_idx(cnt_q),
    .wr_north(in_north),
    .wr_west(in_west),
    .sk_en(state_d == STREAM),
    .sk_s(cnt_d),
    .arr_north(arr_north),
    .arr_west(arr_west)
  );
  assign busy = state_q != IDLE;
  assign in_ready = state_q == LOAD;
  assign res_valid = state_q == HOLD;
  assign res_data = res_data_q;
  assign arr_clr_n = clr_n_q;
`ifdef BFS_WATCHDOG_EN
  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif
endmodule
